serial_frame_deser: RTL and testbench

//  Downstream consumer of the serial pattern generator's 1-bit output O.

---
 rtl/serial_frame_deser_if.sv | 25 ++
 rtl/serial_frame_deser.sv | 115 +++++++++++
 tb/tb_serial_frame_deser.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/serial_frame_deser_if.sv
// Bus bundle for serial_frame_deser: the serial input side and the FWFT word output side.
// The slave modport is the deserializer; the master modport is the bit source and word consumer.
`timescale 1ns/1ps
interface serial_frame_deser_if #(
  parameter int WIDTH = 8
);
  logic             SIN;
  logic             SOF;
  logic [WIDTH-1:0] WORD_OUT;
  logic             VALID;
  logic             READY;
  logic [2:0]       COUNT;
  logic             OVERFLOW;
  logic             FRAME_ERR;

  modport master (
    output SIN, SOF, READY,
    input  WORD_OUT, VALID, COUNT, OVERFLOW, FRAME_ERR
  );

  modport slave (
    input  SIN, SOF, READY,
    output WORD_OUT, VALID, COUNT, OVERFLOW, FRAME_ERR
  );
endinterface

// File: rtl/serial_frame_deser.sv
// Collects LSB-first serial frames into WIDTH-bit words and buffers them in a small
// first-word-fall-through FIFO with sticky overflow and framing-error flags.
`timescale 1ns/1ps
module serial_frame_deser #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input logic                 CLK,
  input logic                 CLEAR,
  serial_frame_deser_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, ASSEMBLE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [WIDTH-1:0] shift, shift_nxt, push_word;
  logic             push, frame_err_set;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow, frame_err;
  logic             valid, full, pop, wr_en, drop;

  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      state <= IDLE;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
    end
  end

  // A SOF inside ASSEMBLE abandons the partial word and restarts on the same edge.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    shift_nxt     = shift;
    push          = 1'b0;
    push_word     = shift;
    frame_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (bus.SOF) begin
          shift_nxt[0] = bus.SIN;
          idx_nxt      = IDX_W'(1);
          state_nxt    = ASSEMBLE;
        end
      end
      ASSEMBLE: begin
        if (bus.SOF) begin
          frame_err_set = 1'b1;
          shift_nxt[0]  = bus.SIN;
          idx_nxt       = IDX_W'(1);
        end else begin
          shift_nxt[idx] = bus.SIN;
          if (idx == IDX_W'(WIDTH - 1)) begin
            push      = 1'b1;
            push_word = {bus.SIN, shift[WIDTH-2:0]};
            idx_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A pop on the same edge frees the head slot, so a full FIFO can still accept the push.
  assign valid = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign pop   = valid & bus.READY;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop)          overflow  <= 1'b1;
      if (frame_err_set) frame_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  assign bus.WORD_OUT  = valid ? mem[rd_ptr] : '0;
  assign bus.VALID     = valid;
  assign bus.COUNT     = 3'(count);
  assign bus.OVERFLOW  = overflow;
  assign bus.FRAME_ERR = frame_err;
endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed bench for serial_frame_deser: framing, FWFT ordering, full/overflow,
// simultaneous push/pop, framing errors and asynchronous clear.
`timescale 1ns/1ps
module tb_serial_frame_deser;
  logic CLK;
  logic CLEAR;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_frame_deser_if #(.WIDTH(8)) bus ();

  serial_frame_deser #(.DEPTH(4), .WIDTH(8)) dut (
    .CLK   (CLK),
    .CLEAR (CLEAR),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge, are sampled on the next one, and
  // the task returns 1ns after that edge so outputs are stable for checking.
  task automatic send_bit(input logic sof, input logic sin, input logic rdy);
    bus.SOF   = sof;
    bus.SIN   = sin;
    bus.READY = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic rdy, input logic rdy_last);
    for (int i = 0; i < 8; i++)
      send_bit(i == 0, b[i], (i == 7) ? rdy_last : rdy);
    bus.SOF   = 1'b0;
    bus.READY = 1'b0;
  endtask

  task automatic fill4();
    send_frame(8'h01, 1'b0, 1'b0);
    send_frame(8'h03, 1'b0, 1'b0);
    send_frame(8'h07, 1'b0, 1'b0);
    send_frame(8'h1F, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_q [4];

    bus.SIN   = 1'b0;
    bus.SOF   = 1'b0;
    bus.READY = 1'b0;
    CLEAR     = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_word",  bus.WORD_OUT, 8'h00);
    check("rst_valid", 8'(bus.VALID), 8'h00);
    check("rst_count", 8'(bus.COUNT), 8'h00);
    check("rst_ovf",   8'(bus.OVERFLOW), 8'h00);
    check("rst_ferr",  8'(bus.FRAME_ERR), 8'h00);
    CLEAR = 1'b1;

    // SIN without SOF in IDLE is ignored
    repeat (3) send_bit(1'b0, 1'b1, 1'b1);
    check("idle_count", 8'(bus.COUNT), 8'h00);

    // Single frame 0F, consumer ready
    send_frame(8'h0F, 1'b1, 1'b1);
    check("t1_valid", 8'(bus.VALID), 8'h01);
    check("t1_word",  bus.WORD_OUT, 8'h0F);
    check("t1_count", 8'(bus.COUNT), 8'h01);
    send_bit(1'b0, 1'b0, 1'b1);
    check("t1_count_pop", 8'(bus.COUNT), 8'h00);
    check("t1_valid_pop", 8'(bus.VALID), 8'h00);

    // Four back-to-back frames, READY low
    fill4();
    check("t2_count", 8'(bus.COUNT), 8'h04);
    check("t2_head",  bus.WORD_OUT, 8'h01);
    check("t2_ovf",   8'(bus.OVERFLOW), 8'h00);
    check("t2_ferr",  8'(bus.FRAME_ERR), 8'h00);
    exp_q = '{8'h01, 8'h03, 8'h07, 8'h1F};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_pop%0d", k), bus.WORD_OUT, exp_q[k]);
      send_bit(1'b0, 1'b0, 1'b1);
    end
    bus.READY = 1'b0;
    check("t2_empty", 8'(bus.VALID), 8'h00);

    // Full FIFO, completing edge pops and pushes together
    fill4();
    send_frame(8'h3F, 1'b0, 1'b1);
    check("t4_count", 8'(bus.COUNT), 8'h04);
    check("t4_ovf",   8'(bus.OVERFLOW), 8'h00);
    check("t4_head",  bus.WORD_OUT, 8'h03);
    exp_q = '{8'h03, 8'h07, 8'h1F, 8'h3F};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t4_pop%0d", k), bus.WORD_OUT, exp_q[k]);
      send_bit(1'b0, 1'b0, 1'b1);
    end
    bus.READY = 1'b0;
    check("t4_empty", 8'(bus.COUNT), 8'h00);

    // Full FIFO, fifth frame dropped
    fill4();
    send_frame(8'hFF, 1'b0, 1'b0);
    check("t3_ovf",   8'(bus.OVERFLOW), 8'h01);
    check("t3_count", 8'(bus.COUNT), 8'h04);
    check("t3_head",  bus.WORD_OUT, 8'h01);
    exp_q = '{8'h01, 8'h03, 8'h07, 8'h1F};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_pop%0d", k), bus.WORD_OUT, exp_q[k]);
      send_bit(1'b0, 1'b0, 1'b1);
    end
    bus.READY = 1'b0;
    check("t3_empty", 8'(bus.VALID), 8'h00);
    check("t3_ovf_sticky", 8'(bus.OVERFLOW), 8'h01);

    // Truncated frame followed by a full 7F frame
    send_bit(1'b1, 1'b1, 1'b0);
    repeat (3) send_bit(1'b0, 1'b0, 1'b0);
    check("t5_ferr_pre", 8'(bus.FRAME_ERR), 8'h00);
    send_frame(8'h7F, 1'b0, 1'b0);
    check("t5_ferr",  8'(bus.FRAME_ERR), 8'h01);
    check("t5_count", 8'(bus.COUNT), 8'h01);
    check("t5_word",  bus.WORD_OUT, 8'h7F);

    // Asynchronous clear mid-frame with two words buffered
    send_frame(8'h55, 1'b0, 1'b0);
    check("t6_count_pre", 8'(bus.COUNT), 8'h02);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    #2;
    CLEAR = 1'b0;
    #1;
    check("t6_word",  bus.WORD_OUT, 8'h00);
    check("t6_valid", 8'(bus.VALID), 8'h00);
    check("t6_count", 8'(bus.COUNT), 8'h00);
    check("t6_ovf",   8'(bus.OVERFLOW), 8'h00);
    check("t6_ferr",  8'(bus.FRAME_ERR), 8'h00);
    @(posedge CLK);
    #1;
    CLEAR = 1'b1;
    send_frame(8'h3F, 1'b0, 1'b0);
    check("t6_post_word",  bus.WORD_OUT, 8'h3F);
    check("t6_post_count", 8'(bus.COUNT), 8'h01);
    check("t6_post_ferr",  8'(bus.FRAME_ERR), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
